// File: rtl/axis_frame_packer_pkg.sv
// -----------------------------------------------------------------------------
// axis_frame_packer_pkg
//   Shared definitions for the frame packer that sits in front of the forward
//   VAE AXIS stage.
//
//   Contents:
//     - sample width, lanes per output word and the derived output data width;
//     - frame length in words, which must equal the forward stage's input
//       memory depth;
//     - the width of the word counter;
//     - the packer state encoding.
// -----------------------------------------------------------------------------
package axis_frame_packer_pkg;

   localparam int SAMPLE_WIDTH = 16;
   localparam int LANES        = 4;
   localparam int DATA_WIDTH   = SAMPLE_WIDTH * LANES;

   // Input memory depth of the forward VAE stage. Every frame the packer emits
   // must be exactly this many words long.
   localparam int VAE_FRAME_DEPTH = 21;
   localparam int FRAME_WORDS     = VAE_FRAME_DEPTH;
   localparam int WCNT_WIDTH      = 5;

   typedef enum logic [0:0] {
      FILL = 1'b0,   // gathering samples into the partial word
      PAD  = 1'b1    // source frame ended early, emitting zero words
   } state_t;

endpackage : axis_frame_packer_pkg

// File: rtl/axis_frame_packer_out.sv
// -----------------------------------------------------------------------------
// axis_out_reg
//   Single-entry AXIS output register with valid/ready hold.
//
//   The register accepts a new word only when it is free, meaning it is
//   empty or its current word is being taken this cycle. While a word is
//   stalled, data and last stay frozen, and valid drops only after a
//   handshake.
//
//   Ports:
//     aclk, areset    clock and synchronous active-high reset
//     load            write ld_data/ld_last (caller asserts only when free)
//     ld_data         word to present
//     ld_last         tlast flag for that word
//     free            register may be loaded this cycle
//     m_axis_tdata    registered output word
//     m_axis_tvalid   output word valid
//     m_axis_tlast    output word is last of frame
//     m_axis_tready   downstream ready
// -----------------------------------------------------------------------------
module axis_out_reg
   import axis_frame_packer_pkg::*;
#(
   parameter int DW = DATA_WIDTH
) (
   input  logic          aclk,
   input  logic          areset,
   input  logic          load,
   input  logic [DW-1:0] ld_data,
   input  logic          ld_last,
   output logic          free,
   output logic [DW-1:0] m_axis_tdata,
   output logic          m_axis_tvalid,
   output logic          m_axis_tlast,
   input  logic          m_axis_tready
);

   assign free = !m_axis_tvalid || m_axis_tready;

   always_ff @(posedge aclk) begin
      if (areset) begin
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else if (load) begin
         m_axis_tdata  <= ld_data;
         m_axis_tvalid <= 1'b1;
         m_axis_tlast  <= ld_last;
      end else if (m_axis_tready) begin
         // Word taken and nothing new to load. Data and last keep their
         // stale values because they are ignored while valid is low.
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule : axis_out_reg

// File: rtl/axis_frame_packer.sv
// -----------------------------------------------------------------------------
// axis_frame_packer
//   Packs a stream of 16-bit fixed-point samples (weights, then inputs) four
//   per 64-bit AXIS word. Frames are always FRAME_WORDS words long, with tlast
//   on the final word.
//
//   If the source raises s_tlast before the frame is full, the packer pads
//   the remainder of the frame with zero words. If the source never raises
//   s_tlast, the frame closes on its own after FRAME_WORDS words and the next
//   sample starts a new frame.
//
//   Ports:
//     aclk, areset     clock and synchronous active-high reset
//     s_tdata          input sample
//     s_tvalid         input sample valid
//     s_tlast          last sample of the source frame
//     s_tready         packer accepts a sample this cycle
//     m_axis_tdata     packed word; lane k = bits [16k+15:16k],
//                      first sample in lane 0
//     m_axis_tvalid    packed word valid
//     m_axis_tlast     final word of the frame
//     m_axis_tready    downstream ready
//     frame_done       one-cycle pulse after the tlast word is handshaked
//     pad_active       high while zero-pad words are being emitted
// -----------------------------------------------------------------------------
module axis_frame_packer #(
   parameter int SAMPLE_WIDTH = axis_frame_packer_pkg::SAMPLE_WIDTH,
   parameter int LANES        = axis_frame_packer_pkg::LANES,
   parameter int FRAME_WORDS  = axis_frame_packer_pkg::FRAME_WORDS,
   parameter int WCNT_WIDTH   = axis_frame_packer_pkg::WCNT_WIDTH
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [SAMPLE_WIDTH-1:0]   s_tdata,
   input  logic                      s_tvalid,
   input  logic                      s_tlast,
   output logic                      s_tready,
   output logic [SAMPLE_WIDTH*LANES-1:0] m_axis_tdata,
   output logic                      m_axis_tvalid,
   output logic                      m_axis_tlast,
   input  logic                      m_axis_tready,
   output logic                      frame_done,
   output logic                      pad_active
);

   import axis_frame_packer_pkg::*;

   localparam int DW     = SAMPLE_WIDTH * LANES;
   localparam int LCNT_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LCNT_W-1:0]     LANE_LAST = LCNT_W'(LANES - 1);
   localparam logic [WCNT_WIDTH-1:0] WORD_LAST = WCNT_WIDTH'(FRAME_WORDS - 1);

   state_t                  state_p0, state_nxt;
   logic [LCNT_W-1:0]       lane_cnt_p0;
   logic [WCNT_WIDTH-1:0]   word_cnt_p0;
   logic [DW-1:0]           part_p0;
   logic                    vld_p1;

   logic                    free;
   logic                    accept;
   logic                    word_done;
   logic                    last_word;
   logic                    pad_load;
   logic                    out_load;
   logic                    out_last;
   logic [DW-1:0]           merged;
   logic [DW-1:0]           out_data;

   // Returns buf_in with sample smp written into lane `lane`.
   function automatic logic [DW-1:0] place_sample(
      input logic [DW-1:0]           buf_in,
      input logic [LCNT_W-1:0]       lane,
      input logic [SAMPLE_WIDTH-1:0] smp
   );
      logic [DW-1:0] r;
      r = buf_in;
      r[int'(lane)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = smp;
      return r;
   endfunction

   // ---- stage p0: state register ------------------------------------------
   always_ff @(posedge aclk) begin
      if (areset) state_p0 <= FILL;
      else        state_p0 <= state_nxt;
   end

   // ---- next-state logic ---------------------------------------------------
   always_comb begin
      state_nxt = state_p0;
      case (state_p0)
         FILL: if (word_done && s_tlast && !last_word) state_nxt = PAD;
         PAD:  if (pad_load && last_word)              state_nxt = FILL;
         default:                                      state_nxt = FILL;
      endcase
   end

   // ---- outputs and datapath controls --------------------------------------
   always_comb begin
      last_word = (word_cnt_p0 == WORD_LAST);
      // Both controls are gated during reset so that nothing is accepted or
      // advertised in the reset cycle, whatever state was left behind.
      s_tready   = !areset && (state_p0 == FILL) && free;
      pad_active = !areset && (state_p0 == PAD);
      accept     = s_tvalid && s_tready;
      word_done  = accept && ((lane_cnt_p0 == LANE_LAST) || s_tlast);
      pad_load   = pad_active && free;
      out_load   = word_done || pad_load;
      merged     = place_sample(part_p0, lane_cnt_p0, s_tdata);
      out_data   = pad_load ? '0 : merged;
      out_last   = last_word;
   end

   // ---- stage p0: partial word and counters --------------------------------
   always_ff @(posedge aclk) begin
      if (areset) begin
         lane_cnt_p0 <= '0;
         part_p0     <= '0;
         word_cnt_p0 <= '0;
      end else begin
         if (word_done) begin
            lane_cnt_p0 <= '0;
            part_p0     <= '0;
         end else if (accept) begin
            lane_cnt_p0 <= lane_cnt_p0 + 1'b1;
            part_p0     <= merged;
         end
         if (out_load) begin
            word_cnt_p0 <= last_word ? '0 : word_cnt_p0 + 1'b1;
         end
      end
   end

   // ---- stage p1: output register ------------------------------------------
   axis_out_reg #(
      .DW (DW)
   ) u_out_reg (
      .aclk          (aclk),
      .areset        (areset),
      .load          (out_load),
      .ld_data       (out_data),
      .ld_last       (out_last),
      .free          (free),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready)
   );

   // ---- stage p2: frame completion pulse -----------------------------------
   assign vld_p1 = m_axis_tvalid && m_axis_tready && m_axis_tlast;

   always_ff @(posedge aclk) begin
      if (areset) frame_done <= 1'b0;
      else        frame_done <= vld_p1;
   end

endmodule : axis_frame_packer

// File: tb/tb_axis_frame_packer.sv
module tb_axis_frame_packer;

   logic        aclk = 1'b0;
   logic        areset;
   logic [15:0] s_tdata;
   logic        s_tvalid;
   logic        s_tlast;
   logic        s_tready;
   logic [63:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_tready;
   logic        frame_done;
   logic        pad_active;

   axis_frame_packer dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_tdata       (s_tdata),
      .s_tvalid      (s_tvalid),
      .s_tlast       (s_tlast),
      .s_tready      (s_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .frame_done    (frame_done),
      .pad_active    (pad_active)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [63:0] d;
      logic        l;
      logic        p;
   } word_t;

   word_t       q[$];
   int          checks = 0;
   int          errors = 0;
   int          fd_cnt = 0;
   int          stall_cnt = 0;
   int          rdy_bad = 0;
   bit          rand_rdy = 1'b0;
   bit          track_rdy = 1'b0;
   bit          stall_prev = 1'b0;
   logic [63:0] prev_data;
   logic        prev_last;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Output monitor: records handshaked words, frame_done pulses, and checks
   // that a stalled word stays frozen.
   always @(negedge aclk) begin
      if (!areset) begin
         if (stall_prev) begin
            chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
            chk("stall_data", m_axis_tdata, prev_data);
            chk("stall_last", 64'(m_axis_tlast), 64'(prev_last));
         end
         if (track_rdy && q.size() < 20 && s_tready) rdy_bad++;
         if (m_axis_tvalid && m_axis_tready)
            q.push_back('{d: m_axis_tdata, l: m_axis_tlast, p: pad_active});
         if (frame_done) fd_cnt++;
      end
      stall_prev = !areset && m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
   end

   task automatic tick();
      @(posedge aclk);
      #1;
      if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input int v, input logic last);
      bit done;
      int n;
      done = 1'b0;
      n = 0;
      s_tdata  = 16'(v);
      s_tvalid = 1'b1;
      s_tlast  = last;
      while (!done) begin
         @(negedge aclk);
         done = s_tready;
         if (!done) stall_cnt++;
         tick();
         n++;
         if (!done && n > 500) begin
            $display("FAIL send_timeout observed=stalled expected=accepted");
            $fatal(1);
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_run(input int first, input int count, input bit with_last);
      for (int i = 0; i < count; i++)
         send(first + i, with_last && (i == count - 1));
   endtask

   task automatic wait_words(input int n);
      int c;
      c = 0;
      while (q.size() < n && c < 3000) begin
         tick();
         c++;
      end
      if (q.size() < n) chk("wait_words_timeout", 64'(q.size()), 64'(n));
      repeat (4) tick();
   endtask

   function automatic logic [63:0] pack4(input int a);
      return {16'(a + 3), 16'(a + 2), 16'(a + 1), 16'(a)};
   endfunction

   int n_last;
   int n_ok;

   initial begin
      areset        = 1'b1;
      s_tdata       = '0;
      s_tvalid      = 1'b0;
      s_tlast       = 1'b0;
      m_axis_tready = 1'b1;

      // reset state
      repeat (2) tick();
      @(negedge aclk);
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
      chk("rst_tdata", m_axis_tdata, 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      chk("rst_pad_active", 64'(pad_active), 64'd0);
      chk("rst_s_tready", 64'(s_tready), 64'd0);
      tick();
      areset = 1'b0;
      tick();

      // 1: full 84-sample frame
      q.delete(); fd_cnt = 0; stall_cnt = 0;
      send_run(1, 84, 1'b1);
      wait_words(21);
      chk("t1_count", 64'(q.size()), 64'd21);
      chk("t1_word0", q[0].d, 64'h0004_0003_0002_0001);
      chk("t1_word10", q[10].d, 64'h002C_002B_002A_0029);
      chk("t1_word20", q[20].d, 64'h0054_0053_0052_0051);
      n_last = 0;
      foreach (q[i]) if (q[i].l) n_last++;
      chk("t1_tlast_count", 64'(n_last), 64'd1);
      chk("t1_tlast_w20", 64'(q[20].l), 64'd1);
      chk("t1_frame_done", 64'(fd_cnt), 64'd1);
      chk("t1_s_tready_stalls", 64'(stall_cnt), 64'd0);

      // 2: short frame of 10 samples, padded
      q.delete(); fd_cnt = 0; rdy_bad = 0;
      send_run(1, 10, 1'b1);
      track_rdy = 1'b1;
      wait_words(21);
      track_rdy = 1'b0;
      chk("t2_count", 64'(q.size()), 64'd21);
      chk("t2_word1", q[1].d, 64'h0008_0007_0006_0005);
      chk("t2_word2", q[2].d, 64'h0000_0000_000A_0009);
      n_ok = 0;
      for (int i = 3; i <= 20; i++) if (q[i].d == 64'd0) n_ok++;
      chk("t2_zero_words", 64'(n_ok), 64'd18);
      n_ok = 0;
      for (int i = 3; i <= 19; i++) if (q[i].p) n_ok++;
      chk("t2_pad_active", 64'(n_ok), 64'd17);
      chk("t2_tlast_w20", 64'(q[20].l), 64'd1);
      chk("t2_tlast_w19", 64'(q[19].l), 64'd0);
      chk("t2_s_tready_during_pad", 64'(rdy_bad), 64'd0);
      chk("t2_frame_done", 64'(fd_cnt), 64'd1);
      @(negedge aclk);
      chk("t2_s_tready_after", 64'(s_tready), 64'd1);
      tick();

      // 3: random backpressure, two back-to-back frames
      q.delete(); fd_cnt = 0;
      rand_rdy = 1'b1;
      send_run(1, 84, 1'b1);
      send_run(1, 84, 1'b1);
      wait_words(42);
      rand_rdy = 1'b0;
      m_axis_tready = 1'b1;
      repeat (4) tick();
      chk("t3_count", 64'(q.size()), 64'd42);
      n_ok = 0;
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < 21; i++)
            if (q[f*21 + i].d == pack4(4*i + 1) && q[f*21 + i].l == (i == 20)) n_ok++;
      chk("t3_words_ok", 64'(n_ok), 64'd42);
      chk("t3_f2_word0", q[21].d, 64'h0004_0003_0002_0001);
      chk("t3_frame_done", 64'(fd_cnt), 64'd2);

      // 4: 90 samples without s_tlast, then close with 91,92
      q.delete(); fd_cnt = 0;
      send_run(1, 90, 1'b0);
      wait_words(22);
      chk("t4_count", 64'(q.size()), 64'd22);
      chk("t4_f1_word20", q[20].d, 64'h0054_0053_0052_0051);
      chk("t4_f1_tlast", 64'(q[20].l), 64'd1);
      chk("t4_f2_word0", q[21].d, 64'h0058_0057_0056_0055);
      chk("t4_f2_word0_last", 64'(q[21].l), 64'd0);
      chk("t4_frame_done", 64'(fd_cnt), 64'd1);
      send_run(91, 2, 1'b1);
      wait_words(42);
      chk("t4_held_lanes", q[22].d, 64'h005C_005B_005A_0059);
      chk("t4_f2_tlast", 64'(q[41].l), 64'd1);

      // 5: reset mid-frame
      q.delete(); fd_cnt = 0;
      send_run(1, 30, 1'b0);
      repeat (3) tick();
      chk("t5_pre_tdata", m_axis_tdata, 64'h001C_001B_001A_0019);
      areset = 1'b1;
      s_tdata = 16'h00FF;
      s_tvalid = 1'b1;
      @(negedge aclk);
      chk("t5_rst_s_tready", 64'(s_tready), 64'd0);
      tick();
      areset = 1'b0;
      s_tvalid = 1'b0;
      @(negedge aclk);
      chk("t5_post_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("t5_post_tdata", m_axis_tdata, 64'd0);
      tick();
      q.delete(); fd_cnt = 0;
      send_run(1, 84, 1'b1);
      wait_words(21);
      chk("t5_count", 64'(q.size()), 64'd21);
      chk("t5_word0", q[0].d, 64'h0004_0003_0002_0001);
      chk("t5_word20", q[20].d, 64'h0054_0053_0052_0051);
      chk("t5_frame_done", 64'(fd_cnt), 64'd1);

      // 6: s_tlast on sample 4
      q.delete(); fd_cnt = 0;
      send_run(1, 4, 1'b1);
      wait_words(21);
      chk("t6_count", 64'(q.size()), 64'd21);
      chk("t6_word0", q[0].d, 64'h0004_0003_0002_0001);
      n_ok = 0;
      for (int i = 1; i <= 20; i++) if (q[i].d == 64'd0) n_ok++;
      chk("t6_zero_words", 64'(n_ok), 64'd20);
      n_last = 0;
      foreach (q[i]) if (q[i].l) n_last++;
      chk("t6_tlast_count", 64'(n_last), 64'd1);
      chk("t6_tlast_w20", 64'(q[20].l), 64'd1);
      chk("t6_frame_done", 64'(fd_cnt), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_axis_frame_packer
